// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   owner_t : which port owns the in-flight access
//   acc_t   : latched access payload (we, addr, wdata)
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned STARVE_MAX_DEF = 3;
  localparam int unsigned CNT_W          = 3;
  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned INSN_W         = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_D  = 1'b0,
    OWN_IF = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational winner select between fetch and data requests.
//   if_req, d_req : pending requests
//   starve_full   : fetch has lost the maximum number of rounds
//   if_win, d_win : one-hot (or zero) winner
module arb_priority_pick (
  input  logic if_req,
  input  logic d_req,
  input  logic starve_full,
  output logic if_win,
  output logic d_win
);

  // Data wins by default; a starved fetch takes the round instead.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (if_req && starve_full) begin
      if_win = 1'b1;
    end else if (d_req) begin
      d_win = 1'b1;
    end else if (if_req) begin
      if_win = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto a single memory port.
//   clk, rst                       : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt/if_done/if_rdata        : fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_done/d_rdata : data port
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata      : memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [INSN_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] starve_cnt;
  owner_t           owner;
  acc_t             acc_q;

  logic arb_en, in_busy, in_resp;
  logic if_win, d_win, starve_full;

  assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));

  arb_priority_pick u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .starve_full (starve_full),
    .if_win      (if_win),
    .d_win       (d_win)
  );

  // Phase decode; everything is forced quiet in the reset cycle.
  assign arb_en  = !rst && ((state == IDLE) || (state == RESP));
  assign in_busy = !rst && (state == BUSY);
  assign in_resp = !rst && (state == RESP);

  assign if_gnt    = arb_en && if_win;
  assign d_gnt     = arb_en && d_win;
  assign mem_en    = in_busy;
  assign mem_we    = in_busy && acc_q.we;
  assign mem_addr  = rst ? '0 : acc_q.addr;
  assign mem_wdata = rst ? '0 : acc_q.wdata;
  assign if_done   = in_resp && (owner == OWN_IF);
  assign d_done    = in_resp && (owner == OWN_D);
  assign if_rdata  = if_done ? mem_rdata[INSN_W-1:0] : '0;
  assign d_rdata   = (d_done && !acc_q.we) ? mem_rdata : '0;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // FSM next state: arbitrate in IDLE/RESP, count MEM_LAT cycles in BUSY.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE, RESP: begin
        if (if_win || d_win) begin
          state_n = BUSY;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(MEM_LAT - 1)) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Access latch, owner and fetch starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      owner      <= OWN_D;
      starve_cnt <= '0;
    end else begin
      if (d_gnt) begin
        acc_q <= '{we: d_we, addr: d_addr, wdata: d_wdata};
        owner <= OWN_D;
      end else if (if_gnt) begin
        // Fetch is read-only.
        acc_q <= '{we: 1'b0, addr: if_addr, wdata: '0};
        owner <= OWN_IF;
      end
      if (if_gnt) begin
        starve_cnt <= '0;
      end else if (arb_en && if_req && d_win && !starve_full) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=3).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_gnt, if_done;
  logic [15:0] if_rdata;
  logic        d_req, d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_done;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int dgrants;
  bit ifg_seen;

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 8'h10;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    // Reset, with fetch request held across it.
    tick(); tick(); #1;
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_d_done", 32'(d_done), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    tick(); rst = 1'b0; #1;

    // Fetch only: gnt at T, mem_en T+1..T+2, done T+3.
    chk("f_if_gnt_T", 32'(if_gnt), 1);
    chk("f_d_gnt_T", 32'(d_gnt), 0);
    tick(); if_req = 1'b0; #1;
    chk("f_mem_en_T1", 32'(mem_en), 1);
    chk("f_mem_addr_T1", 32'(mem_addr), 32'h10);
    chk("f_mem_we_T1", 32'(mem_we), 0);
    tick(); #1;
    chk("f_mem_en_T2", 32'(mem_en), 1);
    tick(); mem_rdata = 32'h0000_A5A5; #1;
    chk("f_mem_en_T3", 32'(mem_en), 0);
    chk("f_if_done_T3", 32'(if_done), 1);
    chk("f_if_rdata", 32'(if_rdata), 32'hA5A5);
    chk("f_d_done_T3", 32'(d_done), 0);
    tick(); #1;
    chk("f_if_done_T4", 32'(if_done), 0);

    // Simultaneous STORE and fetch: data first, fetch granted in RESP.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 8'h30; #1;
    chk("s_d_gnt_T", 32'(d_gnt), 1);
    chk("s_if_gnt_T", 32'(if_gnt), 0);
    tick(); d_req = 1'b0; #1;
    chk("s_mem_we_T1", 32'(mem_we), 1);
    chk("s_mem_addr_T1", 32'(mem_addr), 32'h20);
    chk("s_mem_wdata_T1", mem_wdata, 32'hDEADBEEF);
    chk("s_if_gnt_busy", 32'(if_gnt), 0);
    tick(); #1;
    chk("s_mem_we_T2", 32'(mem_we), 1);
    tick(); #1;
    chk("s_d_done_T3", 32'(d_done), 1);
    chk("s_if_gnt_T3", 32'(if_gnt), 1);
    chk("s_mem_en_T3", 32'(mem_en), 0);
    tick(); if_req = 1'b0; #1;
    chk("s_f_mem_addr", 32'(mem_addr), 32'h30);
    chk("s_f_mem_we", 32'(mem_we), 0);
    tick(); tick(); #1;
    chk("s_f_if_done", 32'(if_done), 1);
    chk("s_f_d_done", 32'(d_done), 0);
    tick();

    // Both held: three data grants then a starved fetch wins.
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h01; if_req = 1'b1; if_addr = 8'h40;
    dgrants = 0; ifg_seen = 1'b0;
    for (int c = 0; c < 20 && !ifg_seen; c++) begin
      #1;
      if (if_gnt) begin
        ifg_seen = 1'b1;
        chk("st_d_gnt_with_if", 32'(d_gnt), 0);
        chk("st_starve_full", 32'(dut.starve_cnt), 3);
      end else if (d_gnt) begin
        dgrants++;
      end
      tick();
    end
    chk("st_if_gnt_seen", 32'(ifg_seen), 1);
    chk("st_d_grants", 32'(dgrants), 3);
    chk("st_starve_clear", 32'(dut.starve_cnt), 0);
    d_req = 1'b0; if_req = 1'b0;
    tick(); tick(); #1;
    chk("st_if_done", 32'(if_done), 1);
    tick();

    // LOAD: d_rdata passes mem_rdata, mem_we low throughout.
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05; #1;
    chk("l_d_gnt_T", 32'(d_gnt), 1);
    tick(); d_req = 1'b0; #1;
    chk("l_mem_we_T1", 32'(mem_we), 0);
    chk("l_mem_addr_T1", 32'(mem_addr), 32'h05);
    tick(); #1;
    chk("l_mem_en_T2", 32'(mem_en), 1);
    chk("l_mem_we_T2", 32'(mem_we), 0);
    tick(); mem_rdata = 32'h1234_5678; #1;
    chk("l_d_done_T3", 32'(d_done), 1);
    chk("l_d_rdata", d_rdata, 32'h1234_5678);
    chk("l_if_done_T3", 32'(if_done), 0);
    tick();

    // Reset mid-STORE abandons it; held fetch granted right after.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h44; d_wdata = 32'h0BAD_F00D; #1;
    chk("r_d_gnt_T", 32'(d_gnt), 1);
    tick(); d_req = 1'b0; if_req = 1'b1; if_addr = 8'h50; #1;
    chk("r_mem_en_T1", 32'(mem_en), 1);
    chk("r_if_gnt_busy", 32'(if_gnt), 0);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("r_mem_en_T2", 32'(mem_en), 0);
    chk("r_d_done_T2", 32'(d_done), 0);
    chk("r_state_T2", 32'(dut.state), 32'(IDLE));
    chk("r_if_gnt_T2", 32'(if_gnt), 1);
    tick(); if_req = 1'b0; #1;
    chk("r_d_done_T3", 32'(d_done), 0);
    chk("r_mem_addr_T3", 32'(mem_addr), 32'h50);
    chk("r_mem_we_T3", 32'(mem_we), 0);
    tick(); tick(); #1;
    chk("r_if_done", 32'(if_done), 1);
    chk("r_d_done_resp", 32'(d_done), 0);
    tick();

    // Fetch pulse during BUSY is ignored.
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h07; #1;
    chk("b_d_gnt_T", 32'(d_gnt), 1);
    tick(); d_req = 1'b0; if_req = 1'b1; if_addr = 8'h60; #1;
    chk("b_if_gnt_T1", 32'(if_gnt), 0);
    tick(); if_req = 1'b0; #1;
    chk("b_if_gnt_T2", 32'(if_gnt), 0);
    tick(); #1;
    chk("b_d_done_T3", 32'(d_done), 1);
    chk("b_if_gnt_T3", 32'(if_gnt), 0);
    tick(); #1;
    chk("b_mem_en_T4", 32'(mem_en), 0);
    chk("b_if_gnt_T4", 32'(if_gnt), 0);
    tick(); #1;
    chk("b_mem_en_T5", 32'(mem_en), 0);
    chk("b_if_done_T5", 32'(if_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
